wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the maximum number of consecutive pipeline grants while long-latency results wait.
REQ-002 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port wb_i_valid, input, 1: pipeline W-stage holds an instruction this cycle.
REQ-005 Port wb_i_wen, input, 1: W-stage instruction writes the register file.
REQ-006 Port wb_i_rd, input, 5: W-stage destination register.
REQ-007 Port wb_i_data, input, 64: W-stage write data.
REQ-008 Port wb_o_stall, output, 1: hold W stage; pipeline re-presents the same request next cycle.
REQ-009 Port lu_i_valid, input, 1: long-latency unit (divider / miss-load return) offers a result.
REQ-010 Port lu_i_rd, input, 5: long-latency result destination.
REQ-011 Port lu_i_data, input, 64: long-latency result data.
REQ-012 Port lu_o_ready, output, 1: arbiter accepts the long-latency result this cycle.
REQ-013 Port rf_o_wen, output, 1: register-file write enable.
REQ-014 Port rf_o_rd, output, 5: register-file write address.
REQ-015 Port rf_o_data, output, 64: register-file write data.

Function
REQ-016 Long-latency results SHALL enter a 2-entry FIFO (entries: rd, data); push when lu_i_valid && lu_o_ready.
REQ-017 lu_o_ready SHALL equal (count < 2), from registered count only; no same-cycle pop/push bypass when full.
REQ-018 A pipeline request is active when wb_i_valid && wb_i_wen; otherwise the port is free for the FIFO without stalling.
REQ-019 The FIFO head SHALL be granted when count > 0 and any of: no pipeline request; count == 2; starve counter == STARVE_LIMIT; pipeline request with wb_i_rd != 0 matching rd of any valid FIFO entry (WAW order).
REQ-020 Otherwise an active pipeline request SHALL be granted; exactly one grant per cycle maximum.
REQ-021 wb_o_stall SHALL be 1, combinationally, exactly when a pipeline request is active and the FIFO head is granted; 0 otherwise, including count == 0.
REQ-022 A FIFO grant SHALL pop the head at the same edge; a simultaneous push enters behind the remaining entries.
REQ-023 Starve counter: +1 (saturating at STARVE_LIMIT) when count > 0 and pipeline granted; cleared on FIFO grant or when count == 0.
REQ-024 Granted request SHALL appear on rf_o_rd/rf_o_data one cycle after grant (registered, latency 1).
REQ-025 rf_o_wen SHALL be 1 the cycle after a grant whose rd != 0; rd == 0 grants consume the slot (FIFO still pops) with rf_o_wen = 0.
REQ-026 With no grant, rf_o_wen SHALL be 0 next cycle; rf_o_rd/rf_o_data hold last value.
REQ-027 FIFO SHALL never overflow or underflow; pop only when count > 0.

Reset
REQ-028 rst_n low SHALL immediately clear FIFO count, pointers, starve counter, rf_o_wen, rf_o_rd, rf_o_data to 0; lu_o_ready becomes 1 and wb_o_stall 0.
REQ-029 Reset mid-operation SHALL discard queued FIFO entries; no register-file write follows reset release until a new grant.

Verification
REQ-030 Idle pipeline, lu result rd=5 data=0xAA -> next cycle rf_o_wen=1 rd=5 data=0xAA, wb_o_stall=0 throughout.
REQ-031 Pipeline writes rd=3 every cycle; one lu entry rd=7 pending -> 4 pipeline writes, then wb_o_stall=1 for 1 cycle and rd=7 written, then pipeline resumes with the held rd=3 write.
REQ-032 Pipeline busy, two lu results pushed -> count=2, lu_o_ready=0, next cycle stall=1 and FIFO head drained; lu_o_ready returns 1.
REQ-033 FIFO holds rd=9; pipeline presents rd=9 -> stall=1 until rd=9 FIFO entry written, then pipeline rd=9 written one cycle later (final value = pipeline data).
REQ-034 lu result rd=0 data=0x1 -> FIFO pops, rf_o_wen stays 0.
REQ-035 Two entries queued, rst_n pulsed low mid-cycle -> outputs 0 at once, count=0, no write after release.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares one register-file write port between the W stage
// and a 2-entry queue of long-latency results, with starvation and WAW protection.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_i_valid,
    input  logic        wb_i_wen,
    input  logic [4:0]  wb_i_rd,
    input  logic [63:0] wb_i_data,
    output logic        wb_o_stall,
    input  logic        lu_i_valid,
    input  logic [4:0]  lu_i_rd,
    input  logic [63:0] lu_i_data,
    output logic        lu_o_ready,
    output logic        rf_o_wen,
    output logic [4:0]  rf_o_rd,
    output logic [63:0] rf_o_data
);

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [1:0]    count_q, count_d;
    logic          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [4:0]    ent_rd_q   [2];
    logic [63:0]   ent_data_q [2];
    logic [SW-1:0] starve_q, starve_d;
    logic          rf_wen_q, rf_wen_d;
    logic [4:0]    rf_rd_q, rf_rd_d;
    logic [63:0]   rf_data_q, rf_data_d;

    logic pipe_req, waw_hit, fifo_grant, pipe_grant, push;

    always_comb begin
        pipe_req = wb_i_valid & wb_i_wen;
        waw_hit  = 1'b0;
        // Only entries within the live window (head .. head+count-1) can alias.
        for (int unsigned k = 0; k < 2; k++) begin
            if ((2'(k) < count_q) && (ent_rd_q[rd_ptr_q + 1'(k)] == wb_i_rd))
                waw_hit = 1'b1;
        end

        fifo_grant = (count_q != 2'd0) &&
                     (!pipe_req || (count_q == 2'd2) || (starve_q == STARVE_MAX) ||
                      ((wb_i_rd != 5'd0) && waw_hit));
        pipe_grant = pipe_req && !fifo_grant;
        push       = lu_i_valid && (count_q < 2'd2);

        count_d  = count_q + {1'b0, push} - {1'b0, fifo_grant};
        rd_ptr_d = rd_ptr_q ^ fifo_grant;
        wr_ptr_d = wr_ptr_q ^ push;

        starve_d = starve_q;
        if ((count_q == 2'd0) || fifo_grant)
            starve_d = '0;
        else if (pipe_grant && (starve_q != STARVE_MAX))
            starve_d = starve_q + SW'(1);

        rf_wen_d  = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        if (fifo_grant) begin
            rf_rd_d   = ent_rd_q[rd_ptr_q];
            rf_data_d = ent_data_q[rd_ptr_q];
            rf_wen_d  = (ent_rd_q[rd_ptr_q] != 5'd0);
        end else if (pipe_grant) begin
            rf_rd_d   = wb_i_rd;
            rf_data_d = wb_i_data;
            rf_wen_d  = (wb_i_rd != 5'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            starve_q  <= '0;
            rf_wen_q  <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                ent_rd_q[i]   <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            starve_q  <= starve_d;
            rf_wen_q  <= rf_wen_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            if (push) begin
                ent_rd_q[wr_ptr_q]   <= lu_i_rd;
                ent_data_q[wr_ptr_q] <= lu_i_data;
            end
        end
    end

    assign wb_o_stall = pipe_req && fifo_grant;
    assign lu_o_ready = (count_q < 2'd2);
    assign rf_o_wen   = rf_wen_q;
    assign rf_o_rd    = rf_rd_q;
    assign rf_o_data  = rf_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_i_valid, wb_i_wen;
    logic [4:0]  wb_i_rd;
    logic [63:0] wb_i_data;
    logic        wb_o_stall;
    logic        lu_i_valid;
    logic [4:0]  lu_i_rd;
    logic [63:0] lu_i_data;
    logic        lu_o_ready;
    logic        rf_o_wen;
    logic [4:0]  rf_o_rd;
    logic [63:0] rf_o_data;

    int n_vec = 0;
    int n_err = 0;

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_i_valid(wb_i_valid), .wb_i_wen(wb_i_wen), .wb_i_rd(wb_i_rd),
        .wb_i_data(wb_i_data), .wb_o_stall(wb_o_stall),
        .lu_i_valid(lu_i_valid), .lu_i_rd(lu_i_rd), .lu_i_data(lu_i_data),
        .lu_o_ready(lu_o_ready),
        .rf_o_wen(rf_o_wen), .rf_o_rd(rf_o_rd), .rf_o_data(rf_o_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v, wen; logic [4:0] wrd; logic [63:0] wdata;
        logic lv; logic [4:0] lrd; logic [63:0] ldata;
        logic stall, ready, wen_o; logic [4:0] rd_o; logic [63:0] data_o;
    } vec_t;

    typedef struct { logic [4:0] rd; logic [63:0] data; } ent_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic v, wen, input logic [4:0] wrd, input logic [63:0] wdata,
                                input logic lv, input logic [4:0] lrd, input logic [63:0] ldata,
                                input logic stall, ready, wen_o, input logic [4:0] rd_o,
                                input logic [63:0] data_o);
        vec_t r;
        r.v = v; r.wen = wen; r.wrd = wrd; r.wdata = wdata;
        r.lv = lv; r.lrd = lrd; r.ldata = ldata;
        r.stall = stall; r.ready = ready; r.wen_o = wen_o; r.rd_o = rd_o; r.data_o = data_o;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, wen, input logic [4:0] wrd, input logic [63:0] wdata,
                         input logic lv, input logic [4:0] lrd, input logic [63:0] ldata);
        wb_i_valid = v; wb_i_wen = wen; wb_i_rd = wrd; wb_i_data = wdata;
        lu_i_valid = lv; lu_i_rd = lrd; lu_i_data = ldata;
    endtask

    task automatic chk_rf(input string name, input logic wen, input logic [4:0] rd,
                          input logic [63:0] data);
        chk({name, "_wen"}, 64'(rf_o_wen), 64'(wen));
        chk({name, "_rd"}, 64'(rf_o_rd), 64'(rd));
        chk({name, "_data"}, rf_o_data, data);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk_rf("reset", 0, 0, 0);
        chk("reset_ready", 64'(lu_o_ready), 64'd1);
        chk("reset_stall", 64'(wb_o_stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle of a directed sequence: combinational checks mid-cycle, registered after the edge.
    task automatic step(input string name, input logic v, wen, input logic [4:0] wrd,
                        input logic [63:0] wdata, input logic lv, input logic [4:0] lrd,
                        input logic [63:0] ldata, input logic stall,
                        input logic wen_o, input logic [4:0] rd_o, input logic [63:0] data_o);
        @(negedge clk);
        drive(v, wen, wrd, wdata, lv, lrd, ldata);
        #1;
        chk({name, "_stall"}, 64'(wb_o_stall), 64'(stall));
        @(posedge clk);
        #1;
        chk_rf(name, wen_o, rd_o, data_o);
    endtask

    ent_t q[$];
    int   starve;
    logic m_wen; logic [4:0] m_rd; logic [63:0] m_data;

    initial begin
        // Directed table from reset: idle drain, rd=0 drop, full FIFO, non-writing W stage.
        tbl[0]  = mk(0,0,0,0,        1,5,64'hAA,   0,1, 0,0,0);
        tbl[1]  = mk(0,0,0,0,        0,0,0,        0,1, 1,5,64'hAA);
        tbl[2]  = mk(0,0,0,0,        0,0,0,        0,1, 0,5,64'hAA);
        tbl[3]  = mk(0,0,0,0,        1,0,64'h1,    0,1, 0,5,64'hAA);
        tbl[4]  = mk(0,0,0,0,        0,0,0,        0,1, 0,0,64'h1);
        tbl[5]  = mk(1,1,3,64'h33,   1,10,64'h100, 0,1, 1,3,64'h33);
        tbl[6]  = mk(1,1,3,64'h34,   1,11,64'h101, 0,1, 1,3,64'h34);
        tbl[7]  = mk(1,1,3,64'h35,   0,0,0,        1,0, 1,10,64'h100);
        tbl[8]  = mk(1,1,3,64'h35,   0,0,0,        0,1, 1,3,64'h35);
        tbl[9]  = mk(0,0,0,0,        0,0,0,        0,1, 1,11,64'h101);
        tbl[10] = mk(0,0,0,0,        0,0,0,        0,1, 0,11,64'h101);
        tbl[11] = mk(1,0,4,64'h9,    1,12,64'h5,   0,1, 0,11,64'h101);
        tbl[12] = mk(1,0,12,64'h9,   0,0,0,        0,1, 1,12,64'h5);

        reset_dut();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].wen, tbl[i].wrd, tbl[i].wdata, tbl[i].lv, tbl[i].lrd, tbl[i].ldata);
            #1;
            chk($sformatf("tbl%0d_stall", i), 64'(wb_o_stall), 64'(tbl[i].stall));
            chk($sformatf("tbl%0d_ready", i), 64'(lu_o_ready), 64'(tbl[i].ready));
            @(posedge clk);
            #1;
            chk_rf($sformatf("tbl%0d", i), tbl[i].wen_o, tbl[i].rd_o, tbl[i].data_o);
        end

        // Starvation: one pending entry waits out LIMIT pipeline writes, then takes one stall.
        reset_dut();
        step("starve_a", 1,1,3,64'h300, 1,7,64'h77, 0, 1,3,64'h300);
        for (int i = 1; i <= LIMIT; i++)
            step($sformatf("starve_p%0d", i), 1,1,3,64'h300 + 64'(i), 0,0,0, 0, 1,3,64'h300 + 64'(i));
        step("starve_lu", 1,1,3,64'h305, 0,0,0, 1, 1,7,64'h77);
        step("starve_res", 1,1,3,64'h305, 0,0,0, 0, 1,3,64'h305);

        // WAW: pipeline rd=9 waits for the queued rd=9 result, then overwrites it.
        reset_dut();
        step("waw_a", 1,1,3,64'h31, 1,9,64'h99, 0, 1,3,64'h31);
        step("waw_b", 1,1,9,64'hD9, 0,0,0, 1, 1,9,64'h99);
        step("waw_c", 1,1,9,64'hD9, 0,0,0, 0, 1,9,64'hD9);

        // Mid-cycle reset with two queued entries.
        reset_dut();
        step("rst_a", 1,1,3,64'h41, 1,20,64'h20, 0, 1,3,64'h41);
        step("rst_b", 1,1,3,64'h42, 1,21,64'h21, 0, 1,3,64'h42);
        chk("rst_full_ready", 64'(lu_o_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk_rf("rst_now", 0, 0, 0);
        chk("rst_now_ready", 64'(lu_o_ready), 64'd1);
        chk("rst_now_stall", 64'(wb_o_stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst_after%0d_wen", i), 64'(rf_o_wen), 64'd0);
        end

        // Randomized run against the queue model.
        reset_dut();
        q.delete();
        starve = 0;
        m_wen = 0; m_rd = 0; m_data = 0;
        begin
            logic hold;
            logic pv, pw, lv, req, hgrant, waw;
            logic [4:0] prd, lrd;
            logic [63:0] pdata, ldata;
            hold = 0;
            pv = 0; pw = 0; prd = 0; pdata = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                @(negedge clk);
                if (!hold) begin
                    pv = ($urandom_range(0, 9) < 7);
                    pw = ($urandom_range(0, 9) < 8);
                    prd = 5'($urandom_range(0, 7));
                    pdata = {$urandom, $urandom};
                end
                lv = ($urandom_range(0, 9) < 4);
                lrd = 5'($urandom_range(0, 7));
                ldata = {$urandom, $urandom};
                drive(pv, pw, prd, pdata, lv, lrd, ldata);
                #1;
                chk_rf("rnd", m_wen, m_rd, m_data);

                req = pv && pw;
                waw = 0;
                foreach (q[j]) if (q[j].rd == prd) waw = 1;
                hgrant = (q.size() > 0) &&
                         (!req || q.size() == 2 || starve == LIMIT || (prd != 0 && waw));
                chk("rnd_stall", 64'(wb_o_stall), 64'(req && hgrant));
                chk("rnd_ready", 64'(lu_o_ready), 64'(q.size() < 2));

                m_wen = 0;
                if (hgrant) begin
                    m_rd = q[0].rd; m_data = q[0].data; m_wen = (q[0].rd != 0);
                end else if (req) begin
                    m_rd = prd; m_data = pdata; m_wen = (prd != 0);
                end
                if (q.size() == 0 || hgrant) starve = 0;
                else if (req) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
                if (lv && q.size() < 2) begin
                    if (hgrant) void'(q.pop_front());
                    q.push_back('{rd: lrd, data: ldata});
                end else if (hgrant) begin
                    void'(q.pop_front());
                end
                hold = req && hgrant;
            end
            @(negedge clk);
            chk_rf("rnd_last", m_wen, m_rd, m_data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
